// File: rtl/frontend_seq.sv
//============================================================================
// Module      : frontend_seq
// Description : Pulse-echo shot sequencer: tx burst, guard gap, rx sampling.
//               Define TX_DEADTIME_EN to blank the first cycle of every tx
//               half-period.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module frontend_seq #(
    parameter int ADC_WIDTH  = 14,
    parameter int CHANNELS   = 1,
    parameter int DIV_BITS   = 3,
    parameter int ADC_DELAY  = 7,
    parameter int BURST_BITS = 4,
    parameter int WIN_BITS   = 12
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    freqSel,
    input  logic [BURST_BITS-1:0]         burstLen,
    input  logic [WIN_BITS-1:0]           guardLen,
    input  logic [WIN_BITS-1:0]           winLen,
    input  logic [CHANNELS*ADC_WIDTH-1:0] adcPins,
    output logic                          txBurstPos,
    output logic                          txBurstNeg,
    output logic                          txPwdn,
    output logic                          rxPwdn,
    output logic                          rxClk,
    output logic [CHANNELS*ADC_WIDTH-1:0] adcOut,
    output logic                          sampleValid,
    output logic                          done,
    output logic                          busy
);

    localparam int c_cnt_w_a = (WIN_BITS > DIV_BITS) ? WIN_BITS : DIV_BITS;
    localparam int c_cnt_w   = (c_cnt_w_a > 6) ? c_cnt_w_a : 6;
    localparam int c_edge_w  = $clog2(ADC_DELAY + 2);
    localparam logic [DIV_BITS-1:0] c_rx_rise   = DIV_BITS'(1 << (DIV_BITS - 1));
    localparam logic [c_edge_w-1:0] c_edge_last = c_edge_w'(ADC_DELAY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TX    = 2'd1,
        S_GUARD = 2'd2,
        S_RX    = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_next;
    logic [c_cnt_w-1:0]              r_cnt;
    logic [BURST_BITS-1:0]           r_burst;
    logic [c_edge_w-1:0]             r_edge;
    logic [WIN_BITS-1:0]             r_samples;
    logic [1:0]                      r_freq;
    logic [BURST_BITS-1:0]           r_burst_len;
    logic [WIN_BITS-1:0]             r_guard_len;
    logic [WIN_BITS-1:0]             r_win_len;
    logic [CHANNELS*ADC_WIDTH-1:0]   r_adc;
    logic                            r_sample_valid;

    logic [c_cnt_w-1:0] w_half;
    logic [c_cnt_w-1:0] w_period_last;
    logic               w_tx_end;
    logic               w_guard_end;
    logic               w_rx_rise;
    logic               w_last_sample;
    logic               w_done;

    assign w_half        = c_cnt_w'(2) << r_freq;
    assign w_period_last = (w_half << 1) - c_cnt_w'(1);
    assign w_tx_end      = (r_cnt == w_period_last) &&
                           (r_burst == r_burst_len - BURST_BITS'(1));
    assign w_guard_end   = (r_guard_len == '0) ||
                           (r_cnt == c_cnt_w'(r_guard_len) - c_cnt_w'(1));
    assign w_rx_rise     = (r_state == S_RX) && (r_cnt[DIV_BITS-1:0] == c_rx_rise);
    assign w_last_sample = r_sample_valid && (r_samples == r_win_len);

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                // An all-zero shot passes through GUARD for one cycle to emit done.
                if (start) begin
                    if (burstLen != '0)
                        w_next = S_TX;
                    else if ((guardLen != '0) || (winLen == '0))
                        w_next = S_GUARD;
                    else
                        w_next = S_RX;
                end
            end
            S_TX: begin
                if (w_tx_end) begin
                    if (r_guard_len != '0) begin
                        w_next = S_GUARD;
                    end else if (r_win_len != '0) begin
                        w_next = S_RX;
                    end else begin
                        w_next = S_IDLE;
                        w_done = 1'b1;
                    end
                end
            end
            S_GUARD: begin
                if (w_guard_end) begin
                    if (r_win_len != '0) begin
                        w_next = S_RX;
                    end else begin
                        w_next = S_IDLE;
                        w_done = 1'b1;
                    end
                end
            end
            S_RX: begin
                if (w_last_sample) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_burst        <= '0;
            r_edge         <= '0;
            r_samples      <= '0;
            r_freq         <= '0;
            r_burst_len    <= '0;
            r_guard_len    <= '0;
            r_win_len      <= '0;
            r_adc          <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_sample_valid <= 1'b0;

            if (r_state == S_IDLE) begin
                r_cnt   <= '0;
                r_burst <= '0;
                if (start) begin
                    r_freq      <= freqSel;
                    r_burst_len <= burstLen;
                    r_guard_len <= guardLen;
                    r_win_len   <= winLen;
                    r_edge      <= '0;
                    r_samples   <= '0;
                end
            end else if (w_next != r_state) begin
                r_cnt   <= '0;
                r_burst <= '0;
            end else if ((r_state == S_TX) && (r_cnt == w_period_last)) begin
                r_cnt   <= '0;
                r_burst <= r_burst + BURST_BITS'(1);
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            // Early rxClk edges only fill the ADC pipeline and are dropped.
            if (w_rx_rise) begin
                if (r_edge == c_edge_last) begin
                    r_adc          <= adcPins;
                    r_sample_valid <= 1'b1;
                    r_samples      <= r_samples + WIN_BITS'(1);
                end else begin
                    r_edge <= r_edge + c_edge_w'(1);
                end
            end
        end
    end

    logic w_pos_phase;
    logic w_in_tx;
    assign w_in_tx     = (r_state == S_TX);
    assign w_pos_phase = (r_cnt < w_half);

`ifdef TX_DEADTIME_EN
    assign txBurstPos = w_in_tx && w_pos_phase && (r_cnt != '0);
    assign txBurstNeg = w_in_tx && !w_pos_phase && (r_cnt != w_half);
`else
    assign txBurstPos = w_in_tx && w_pos_phase;
    assign txBurstNeg = w_in_tx && !w_pos_phase;
`endif

    assign txPwdn      = !w_in_tx;
    assign rxPwdn      = !((r_state == S_GUARD) || (r_state == S_RX));
    assign rxClk       = (r_state == S_RX) && r_cnt[DIV_BITS-1];
    assign adcOut      = r_adc;
    assign sampleValid = r_sample_valid;
    assign done        = w_done;
    assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_frontend_seq.sv
//============================================================================
// Module      : tb_frontend_seq
// Description : Directed self-checking bench for frontend_seq.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_frontend_seq;

    localparam int c_per         = 8;
    localparam int c_half        = 4;
    localparam int c_delay       = 7;
    localparam int c_first_valid = c_half + c_per * c_delay + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  freqSel;
    logic [3:0]  burstLen;
    logic [11:0] guardLen;
    logic [11:0] winLen;
    logic [13:0] adcPins;
    logic        txBurstPos, txBurstNeg, txPwdn, rxPwdn, rxClk;
    logic [13:0] adcOut;
    logic        sampleValid, done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [13:0] pins [0:511];
    logic [13:0] exp_adc;

    always #5 clk = ~clk;

    frontend_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .freqSel    (freqSel),
        .burstLen   (burstLen),
        .guardLen   (guardLen),
        .winLen     (winLen),
        .adcPins    (adcPins),
        .txBurstPos (txBurstPos),
        .txBurstNeg (txBurstNeg),
        .txPwdn     (txPwdn),
        .rxPwdn     (rxPwdn),
        .rxClk      (rxClk),
        .adcOut     (adcOut),
        .sampleValid(sampleValid),
        .done       (done),
        .busy       (busy)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] outs();
        return {txBurstPos, txBurstNeg, txPwdn, rxPwdn, rxClk, sampleValid, done, busy};
    endfunction

    // Vector order: {pos, neg, txPwdn, rxPwdn, rxClk, sampleValid, done, busy}
    task automatic run_shot(input int fq, input int bu, input int gu, input int wi,
                            input bit hold, input int abort_at);
        int   h, ttx, rx0, cend, ph, r;
        logic pos, neg, in_tx, in_guard, in_rx, rxc, vld;
        h    = 2 << fq;
        ttx  = bu * 2 * h;
        rx0  = ttx + gu + 1;
        cend = (wi == 0) ? (ttx + gu) : (rx0 + c_first_valid + c_per * (wi - 1));

        start    = 1'b1;
        freqSel  = 2'(fq);
        burstLen = 4'(bu);
        guardLen = 12'(gu);
        winLen   = 12'(wi);
        pins[0]  = 14'($urandom);
        adcPins  = pins[0];

        for (int c = 1; c <= cend + 2; c++) begin
            @(posedge clk);
            #1;
            if ((abort_at > 0) && (c == abort_at + 1)) begin
                check_val("abort_outs", 64'(outs()), 64'h30);
                check_val("abort_adc", 64'(adcOut), 64'h0);
                reset   = 1'b0;
                start   = 1'b0;
                exp_adc = '0;
                return;
            end
            in_tx    = (c <= ttx);
            ph       = (c - 1) % (2 * h);
            pos      = in_tx && (ph < h);
            neg      = in_tx && (ph >= h);
`ifdef TX_DEADTIME_EN
            pos      = pos && (ph != 0);
            neg      = neg && (ph != h);
`endif
            in_guard = (c > ttx) && (c <= ttx + gu);
            in_rx    = (wi > 0) && (c >= rx0) && (c <= cend);
            r        = c - rx0;
            rxc      = in_rx && ((r % c_per) >= c_half);
            vld      = in_rx && (r >= c_first_valid) && (((r - c_first_valid) % c_per) == 0);
            check_val($sformatf("wave c=%0d", c), 64'(outs()),
                      64'({pos, neg, !in_tx, !(in_guard || in_rx), rxc, vld, (c == cend), (c <= cend)}));
            if (vld) begin
                exp_adc = pins[c-1];
                check_val($sformatf("adcOut c=%0d", c), 64'(adcOut), 64'(exp_adc));
            end
            pins[c] = 14'($urandom);
            adcPins = pins[c];
            if (hold) start = (c < 50);
            else      start = (c == cend);
            if (hold && (c == 1)) begin
                freqSel  = ~freqSel;
                burstLen = 4'(bu + 5);
                guardLen = 12'(gu + 7);
                winLen   = 12'(wi + 5);
            end
            if (c == abort_at) reset = 1'b1;
        end
        start = 1'b0;
        check_val("adc_hold", 64'(adcOut), 64'(exp_adc));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_adc  = '0;
        reset    = 1'b1;
        start    = 1'b0;
        freqSel  = '0;
        burstLen = '0;
        guardLen = '0;
        winLen   = '0;
        adcPins  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_outs", 64'(outs()), 64'h30);
        check_val("reset_adc", 64'(adcOut), 64'h0);

        // Reset wins over a simultaneous start.
        start    = 1'b1;
        burstLen = 4'd2;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_prio_busy", 64'(busy), 64'h0);

        run_shot(0, 3, 10, 4, 1'b0, 0);
        run_shot(0, 0, 0, 1, 1'b0, 0);
        run_shot(1, 2, 3, 2, 1'b0, 0);
        run_shot(2, 1, 5, 0, 1'b0, 0);
        run_shot(0, 1, 2, 3, 1'b0, 27);
        run_shot(3, 1, 0, 2, 1'b0, 0);
        run_shot(1, 2, 4, 3, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frontend_seq.md
FRONTEND_SEQ -- requirements
Module: frontend_seq

Interface
REQ-001 Parameter ADC_WIDTH, default 14: bits per ADC channel.
REQ-002 Parameter CHANNELS, default 1: number of parallel ADC channels.
REQ-003 Parameter DIV_BITS, default 3: rxClk period = 2^DIV_BITS clk cycles.
REQ-004 Parameter ADC_DELAY, default 7: ADC pipeline latency in rxClk periods.
REQ-005 Parameter BURST_BITS, default 4: width of burstLen.
REQ-006 Parameter WIN_BITS, default 12: width of guardLen and winLen.
REQ-007 clk  in  1  system clock; all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle request to fire one pulse-echo shot.
REQ-010 freqSel  in  2  tx half-period select, H = 2 << freqSel clk cycles (2,4,8,16).
REQ-011 burstLen  in  BURST_BITS  number of full tx cycles per shot.
REQ-012 guardLen  in  WIN_BITS  clk cycles between burst end and rx start.
REQ-013 winLen  in  WIN_BITS  number of samples delivered per shot.
REQ-014 adcPins  in  CHANNELS*ADC_WIDTH  ADC data pins, channel 0 in LSBs.
REQ-015 txBurstPos, txBurstNeg  out  1 each  complementary transducer drive.
REQ-016 txPwdn, rxPwdn  out  1 each  tx driver / ADC power-down, active high.
REQ-017 rxClk  out  1  ADC conversion clock.
REQ-018 adcOut  out  CHANNELS*ADC_WIDTH  captured sample.
REQ-019 sampleValid, done, busy  out  1 each  sample strobe, end-of-shot pulse, shot in progress.

Function
REQ-020 States SHALL be IDLE, TX, GUARD, RX; busy SHALL be high in every state except IDLE.
REQ-021 In IDLE with start high, freqSel/burstLen/guardLen/winLen SHALL be latched and the next state SHALL be TX (GUARD if burstLen=0; RX if also guardLen=0).
REQ-022 start while busy SHALL be ignored; latched values SHALL NOT change mid-shot.
REQ-023 TX SHALL last exactly burstLen*2*H cycles: txBurstPos high for H cycles, then txBurstNeg high for H cycles, repeated; txBurstPos high starting the cycle after start is sampled.
REQ-024 txBurstPos and txBurstNeg SHALL never be high in the same cycle; both low outside TX.
REQ-025 txPwdn SHALL be low only in TX.
REQ-026 GUARD SHALL last exactly guardLen cycles (zero means RX immediately follows TX).
REQ-027 rxPwdn SHALL be low in GUARD and RX, high in IDLE and TX.
REQ-028 In RX, rxClk SHALL be low for the first 2^(DIV_BITS-1) cycles and high for the remaining 2^(DIV_BITS-1) cycles of each period; low outside RX.
REQ-029 adcPins SHALL be registered on each clk cycle in which rxClk rises; rising edges numbered from 0 per shot.
REQ-030 Captures with index < ADC_DELAY SHALL be discarded; each later capture SHALL update adcOut with sampleValid high for exactly one cycle, the cycle after the capture.
REQ-031 After winLen samples, done SHALL pulse coincident with the last sampleValid and the state SHALL return to IDLE the following cycle.
REQ-032 winLen=0 SHALL skip RX entirely: done pulses on the cycle GUARD would exit, then IDLE.
REQ-033 adcOut SHALL hold its last value between strobes and across shots.
REQ-034 start in the same cycle as done SHALL be ignored; a new shot may begin from IDLE the next cycle.

Reset
REQ-035 reset high SHALL force IDLE on the next edge from any state, aborting any shot without done.
REQ-036 Reset values: txBurstPos=0, txBurstNeg=0, txPwdn=1, rxPwdn=1, rxClk=0, adcOut=0, sampleValid=0, done=0, busy=0; all counters 0.
REQ-037 reset SHALL take priority over start in the same cycle.

Configuration
REQ-038 Macro TX_DEADTIME_EN defined: the first clk cycle of every tx half-period SHALL drive both txBurstPos and txBurstNeg low (high time H-1); TX duration unchanged.
REQ-039 Macro TX_DEADTIME_EN undefined: drive per REQ-023 with no dead time.

Verification
REQ-040 Defaults, freqSel=0, burstLen=3, guardLen=10, winLen=4, start pulse -> 12 TX cycles alternating Pos/Neg every 2 cycles, 10 GUARD cycles, 4 sampleValid pulses 8 cycles apart after 7 discarded captures, done with 4th pulse.
REQ-041 adcPins ramp incremented each clk -> adcOut equals the adcPins value at each rxClk rise, sampleValid one cycle later.
REQ-042 burstLen=0, guardLen=0, winLen=1 -> no tx activity, RX starts cycle after start, exactly one sample then done.
REQ-043 reset asserted mid-RX -> next cycle all outputs at reset values, no done; next start runs a full shot.
REQ-044 start held high for 50 cycles during a shot -> exactly one shot; latched parameters unaffected by input changes.
REQ-045 TX_DEADTIME_EN defined, freqSel=1 -> Pos high 3 cycles, gap 1, Neg high 3 cycles; never overlapping.
